// File: rtl/lcd_frame_writer_if.sv
// Control-side to LCD-writer bundle: display registers in, LCD pins and status out.
interface lcd_frame_writer_if;
    logic       start;
    logic [7:0] upper10;
    logic [7:0] upper01;
    logic [7:0] lower1000;
    logic [7:0] lower0100;
    logic [7:0] lower0010;
    logic [7:0] lower0001;
    logic       col;
    logic       point;
    logic       AVS;
    logic       DAY;
    logic       TIM;
    logic       MAX;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic       init_done;
    logic       done;

    modport master (
        output start, upper10, upper01, lower1000, lower0100, lower0010, lower0001,
               col, point, AVS, DAY, TIM, MAX,
        input  lcd_rs, lcd_e, lcd_data, busy, init_done, done
    );

    modport slave (
        input  start, upper10, upper01, lower1000, lower0100, lower0010, lower0001,
               col, point, AVS, DAY, TIM, MAX,
        output lcd_rs, lcd_e, lcd_data, busy, init_done, done
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// HD44780-style 8-bit LCD writer: init sequence after reset, then one 14-byte frame
// per start request, with a per-byte SETUP/EHIGH/HOLD/GAP timing engine.
module lcd_frame_writer #(
    parameter int SETUP_CYC  = 1,
    parameter int E_CYC      = 2,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 40,
    parameter int CLEAR_WAIT = 1600
) (
    input  logic              clock,
    input  logic              reset,
    lcd_frame_writer_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = max2(max2(max2(SETUP_CYC, E_CYC), max2(HOLD_CYC, GAP_CYC)),
                               max2(CLEAR_WAIT, 1));
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_CLRW
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic          init_mode, init_mode_n;
    logic          pending, pending_n;
    logic          busy_n;
    logic          load_byte, launch, fin_frame, fin_init, byte_done, last_byte;
    logic          byte_rs;
    logic [7:0]    byte_data;

    logic          rs_q, e_q, done_q, init_done_q, busy_q;
    logic [7:0]    data_q;

    // frame snapshot, frozen for the whole frame
    logic [7:0]    snap_u10, snap_u01, snap_l1000, snap_l0100, snap_l0010, snap_l0001;
    logic          snap_col, snap_point, snap_avs, snap_day, snap_tim, snap_max;

    // next-state: phase counting per byte, byte sequencing, init/frame completion
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        init_mode_n = init_mode;
        pending_n   = pending;
        load_byte   = 1'b0;
        launch      = 1'b0;
        fin_frame   = 1'b0;
        fin_init    = 1'b0;
        byte_done   = 1'b0;
        last_byte   = init_mode ? (idx == 4'd3) : (idx == 4'd13);
        case (state)
            S_INIT: begin
                state_n   = S_SETUP;
                cnt_n     = '0;
                idx_n     = '0;
                load_byte = 1'b1;
            end
            S_IDLE: begin
                if (bus.start || pending) begin
                    launch      = 1'b1;
                    init_mode_n = 1'b0;
                    idx_n       = '0;
                    cnt_n       = '0;
                    state_n     = S_SETUP;
                    load_byte   = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == CW'(SETUP_CYC - 1)) begin
                    state_n = S_EHIGH;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            S_EHIGH: begin
                if (cnt == CW'(E_CYC - 1)) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            S_HOLD: begin
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    if (GAP_CYC == 0) byte_done = 1'b1;
                    else begin
                        state_n = S_GAP;
                        cnt_n   = '0;
                    end
                end else cnt_n = cnt + 1'b1;
            end
            S_GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) byte_done = 1'b1;
                else cnt_n = cnt + 1'b1;
            end
            S_CLRW: begin
                if (cnt == CW'(CLEAR_WAIT - 1)) begin
                    state_n  = S_IDLE;
                    fin_init = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
            default: state_n = S_INIT;
        endcase

        if (byte_done) begin
            cnt_n = '0;
            if (!last_byte) begin
                idx_n     = idx + 4'd1;
                state_n   = S_SETUP;
                load_byte = 1'b1;
            end else if (init_mode && CLEAR_WAIT != 0) begin
                state_n = S_CLRW;
            end else begin
                state_n   = S_IDLE;
                fin_frame = !init_mode;
                fin_init  = init_mode;
            end
        end

        // start in IDLE always launches, so any other start is a restart request
        if (launch) pending_n = 1'b0;
        else if (bus.start) pending_n = 1'b1;

        busy_n = (state_n != S_IDLE) || pending_n;
    end

    // byte to place on the bus at the next SETUP entry
    always_comb begin
        byte_rs   = 1'b1;
        byte_data = 8'h20;
        if (init_mode_n) begin
            byte_rs = 1'b0;
            case (idx_n[1:0])
                2'd0:    byte_data = 8'h38;
                2'd1:    byte_data = 8'h0C;
                2'd2:    byte_data = 8'h06;
                default: byte_data = 8'h01;
            endcase
        end else begin
            case (idx_n)
                4'd0: begin
                    byte_rs   = 1'b0;
                    byte_data = 8'h80;
                end
                4'd1:  byte_data = snap_u10;
                4'd2:  byte_data = snap_u01;
                4'd4:  byte_data = snap_l1000;
                4'd5:  byte_data = snap_l0100;
                4'd6:  byte_data = snap_col ? 8'h3A : (snap_point ? 8'h2E : 8'h20);
                4'd7:  byte_data = snap_l0010;
                4'd8:  byte_data = snap_l0001;
                4'd10: byte_data = snap_day ? 8'h44 : 8'h2D;
                4'd11: byte_data = snap_avs ? 8'h41 : 8'h2D;
                4'd12: byte_data = snap_tim ? 8'h54 : 8'h2D;
                4'd13: byte_data = snap_max ? 8'h4D : 8'h2D;
                default: byte_data = 8'h20;
            endcase
        end
    end

    // state register and registered LCD/status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_INIT;
            cnt         <= '0;
            idx         <= '0;
            init_mode   <= 1'b1;
            pending     <= 1'b0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            init_mode   <= init_mode_n;
            pending     <= pending_n;
            e_q         <= (state_n == S_EHIGH);
            done_q      <= fin_frame;
            init_done_q <= init_done_q | fin_init;
            busy_q      <= busy_n;
            if (load_byte) begin
                rs_q   <= byte_rs;
                data_q <= byte_data;
            end
        end
    end

    // capture display registers in the launch cycle
    always_ff @(posedge clock) begin
        if (launch) begin
            snap_u10   <= bus.upper10;
            snap_u01   <= bus.upper01;
            snap_l1000 <= bus.lower1000;
            snap_l0100 <= bus.lower0100;
            snap_l0010 <= bus.lower0010;
            snap_l0001 <= bus.lower0001;
            snap_col   <= bus.col;
            snap_point <= bus.point;
            snap_avs   <= bus.AVS;
            snap_day   <= bus.DAY;
            snap_tim   <= bus.TIM;
            snap_max   <= bus.MAX;
        end
    end

    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_e     = e_q;
    assign bus.lcd_data  = data_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.done      = done_q;
endmodule
